// File: rtl/arith_pipe_pkg.sv
// Shared constants and width helpers for the handshaked arithmetic pipeline.
package arith_pipe_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // S1 sum / difference width
   function automatic int sum_w(input int n);
      return n + 1;
   endfunction

   // Nominal S2 width; the top adds one guard bit because s+t can reach 3*(2^N-1)
   function automatic int mid_w(input int n);
      return n + 2;
   endfunction

endpackage

// File: rtl/pipe_stage_ctl.sv
// Per-stage valid flop and advance logic for the arith_pipe_hs pipeline.
module pipe_stage_ctl (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic v_in,
   input  logic adv_next,
   output logic v,
   output logic adv
);

   logic v_q, v_d;

   // A stage may take new data when it is empty or its contents move on
   assign adv = !v_q | adv_next;
   assign v   = v_q;

   always_comb begin
      v_d = v_q;
      if (flush)
         v_d = 1'b0;
      else if (adv)
         v_d = v_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         v_q <= 1'b0;
      else
         v_q <= v_d;
   end

endmodule

// File: rtl/arith_pipe_hs.sv
// Three-stage F = ((A+B) op (C-D)) * D pipeline with valid/ready handshaking.
// Optional accepted-result counter on out_cnt when ARITH_PIPE_CNT_EN is defined.
module arith_pipe_hs
   import arith_pipe_pkg::*;
#(
   parameter int N     = 10,
   parameter int OUT_W = 2*N+2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_op,
   input  logic [N-1:0]     in_a,
   input  logic [N-1:0]     in_b,
   input  logic [N-1:0]     in_c,
   input  logic [N-1:0]     in_d,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef ARITH_PIPE_CNT_EN
   output logic [31:0]      out_cnt,
`endif
   output logic [OUT_W-1:0] out_f
);

   localparam int SUM_W = sum_w(N);
   localparam int XW    = mid_w(N) + 1;

   // Handshake: a beat moves when valid && ready on the same rising edge; a
   // stage holds data and valid while blocked, and ready never depends on the
   // same-side valid, only on downstream state, out_ready and flush.
   logic v1, v2, v3, adv1, adv2, adv3;

   pipe_stage_ctl u_ctl1 (.clk(clk), .rst(rst), .flush(flush), .v_in(in_valid),
                          .adv_next(adv2), .v(v1), .adv(adv1));
   pipe_stage_ctl u_ctl2 (.clk(clk), .rst(rst), .flush(flush), .v_in(v1),
                          .adv_next(adv3), .v(v2), .adv(adv2));
   pipe_stage_ctl u_ctl3 (.clk(clk), .rst(rst), .flush(flush), .v_in(v2),
                          .adv_next(out_ready), .v(v3), .adv(adv3));

   assign in_ready  = adv1 & !flush;
   assign out_valid = v3;

   logic [SUM_W-1:0] s_q, s_d, t_q, t_d;
   logic [N-1:0]     d1_q, d1_d, d2_q, d2_d;
   logic             op_q, op_d;
   logic [XW-1:0]    x_q, x_d;
   logic [OUT_W-1:0] f_q, f_d;
   logic [XW-1:0]    s_ext, t_ext;
   logic signed [OUT_W-1:0] x_sx, d_sx;

   // Data loads only with a valid beat, so out_f keeps its last result when idle
   logic en1, en2, en3;
   assign en1 = adv1 & in_valid & !flush;
   assign en2 = adv2 & v1 & !flush;
   assign en3 = adv3 & v2 & !flush;

   always_comb begin
      s_d   = s_q;
      t_d   = t_q;
      d1_d  = d1_q;
      op_d  = op_q;
      x_d   = x_q;
      d2_d  = d2_q;
      f_d   = f_q;
      s_ext = {2'b00, s_q};
      t_ext = {{2{t_q[SUM_W-1]}}, t_q};
      x_sx  = $signed({{(OUT_W-XW){x_q[XW-1]}}, x_q});
      d_sx  = $signed({{(OUT_W-N){1'b0}}, d2_q});
      if (en1) begin
         s_d  = {1'b0, in_a} + {1'b0, in_b};
         t_d  = {1'b0, in_c} - {1'b0, in_d};
         d1_d = in_d;
         op_d = in_op;
      end
      if (en2) begin
         x_d  = (op_q == OP_SUB) ? (s_ext - t_ext) : (s_ext + t_ext);
         d2_d = d1_q;
      end
      if (en3)
         f_d = x_sx * d_sx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q  <= '0;
         t_q  <= '0;
         d1_q <= '0;
         op_q <= 1'b0;
         x_q  <= '0;
         d2_q <= '0;
         f_q  <= '0;
      end else begin
         s_q  <= s_d;
         t_q  <= t_d;
         d1_q <= d1_d;
         op_q <= op_d;
         x_q  <= x_d;
         d2_q <= d2_d;
         f_q  <= f_d;
      end
   end

   assign out_f = f_q;

`ifdef ARITH_PIPE_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   // Counts consumer-side transfers; flush leaves it alone, wraps naturally
   always_comb begin
      cnt_d = cnt_q + 32'(out_valid & out_ready);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_arith_pipe_hs.sv
// Directed, table-driven bench for arith_pipe_hs (N=10) with an in-order scoreboard.
module tb_arith_pipe_hs;

   localparam int N  = 10;
   localparam int OW = 2*N+2;
   localparam int NV = 13;

   logic          clk, rst, flush, in_valid, in_op, out_ready;
   logic          in_ready, out_valid;
   logic [N-1:0]  in_a, in_b, in_c, in_d;
   logic signed [OW-1:0] out_f;
`ifdef ARITH_PIPE_CNT_EN
   logic [31:0]   out_cnt;
`endif

   arith_pipe_hs #(.N(N)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
      .out_valid(out_valid), .out_ready(out_ready),
`ifdef ARITH_PIPE_CNT_EN
      .out_cnt(out_cnt),
`endif
      .out_f(out_f)
   );

   typedef struct {
      logic [N-1:0]       a, b, c, d;
      logic               op;
      logic signed [63:0] f;
   } vec_t;

   vec_t tbl[NV];
   logic signed [OW-1:0] exp_q[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int gaps = 0;
   int prev_xfer = -1;
   bit track_gaps = 0;

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic void check(input string name, input logic signed [63:0] act,
                                 input logic signed [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // scoreboard: every output transfer pops the oldest expected result
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL out_unexpected: got %0d expected none", out_f);
            end else begin
               check("out_f", out_f, exp_q.pop_front());
            end
            if (track_gaps) begin
               if (prev_xfer >= 0 && cyc != prev_xfer + 1) gaps++;
               prev_xfer = cyc;
            end
         end
      end
   end

   // drivers
   task automatic apply(input vec_t v);
      in_a = v.a; in_b = v.b; in_c = v.c; in_d = v.d; in_op = v.op;
   endtask

   task automatic send(input vec_t v);
      int w = 0;
      apply(v);
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && w < 100) begin
         w++;
         @(negedge clk);
      end
      if (!in_ready) check("send_timeout", 0, 1);
      else exp_q.push_back(v.f[OW-1:0]);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic stream(input int first, input int n, input int max_cyc, output int acc);
      acc = 0;
      for (int c = 0; c < max_cyc && acc < n; c++) begin
         apply(tbl[(first + acc) % NV]);
         in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(tbl[(first + acc) % NV].f[OW-1:0]);
            acc++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int w = 0;
      while (exp_q.size() != 0 && w < 100) begin
         @(posedge clk);
         w++;
      end
      @(posedge clk); #1;
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      int acc;
      tbl[0]  = '{10'd10,   10'd12,   10'd6,    10'd3,    1'b0, 64'sd75};
      tbl[1]  = '{10'd10,   10'd12,   10'd6,    10'd3,    1'b1, 64'sd57};
      tbl[2]  = '{10'd10,   10'd10,   10'd5,    10'd3,    1'b0, 64'sd66};
      tbl[3]  = '{10'd20,   10'd11,   10'd1,    10'd4,    1'b0, 64'sd112};
      tbl[4]  = '{10'd15,   10'd10,   10'd8,    10'd2,    1'b0, 64'sd62};
      tbl[5]  = '{10'd8,    10'd15,   10'd5,    10'd0,    1'b0, 64'sd0};
      tbl[6]  = '{10'd0,    10'd0,    10'd0,    10'd5,    1'b0, -64'sd25};
      tbl[7]  = '{10'd1023, 10'd1023, 10'd1023, 10'd1023, 1'b0, 64'sd2093058};
      tbl[8]  = '{10'd1023, 10'd1023, 10'd1023, 10'd1,    1'b0, 64'sd3068};
      tbl[9]  = '{10'd0,    10'd0,    10'd1023, 10'd1,    1'b1, -64'sd1022};
      tbl[10] = '{10'd0,    10'd0,    10'd0,    10'd1023, 1'b0, -64'sd1046529};
      tbl[11] = '{10'd100,  10'd50,   10'd20,   10'd7,    1'b1, 64'sd959};
      tbl[12] = '{10'd5,    10'd5,    10'd1,    10'd9,    1'b1, 64'sd162};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      apply(tbl[0]);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_f", out_f, 0);
      check("rst_in_ready", in_ready, 1);

      // single transfers: result visible after the second edge following accept
      send(tbl[0]);
      check("lat_edge_k", out_valid, 0);
      @(posedge clk); #1;
      check("lat_edge_k1", out_valid, 0);
      @(posedge clk); #1;
      check("lat_edge_k2", out_valid, 1);
      wait_drain("drain_single_add");
      send(tbl[1]);
      wait_drain("drain_single_sub");

      // whole table back to back at full rate
      track_gaps = 1; prev_xfer = -1; gaps = 0;
      stream(2, NV - 2, NV + 20, acc);
      check("b2b_accepted", acc, NV - 2);
      wait_drain("drain_b2b");
      check("b2b_gaps", gaps, 0);
      track_gaps = 0;

      // backpressure: exactly three fit, result held, then full-pipe shift
      out_ready = 1'b0;
      stream(0, 10, 10, acc);
      check("bp_accepted", acc, 3);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_hold_a", out_f, exp_q[0]);
      repeat (4) @(posedge clk);
      #1;
      check("bp_hold_b", out_f, exp_q[0]);
      out_ready = 1'b1;
      stream(3, 6, 20, acc);
      check("bp_resume_accepted", acc, 6);
      wait_drain("drain_bp");

      // flush with three in flight
      out_ready = 1'b0;
      stream(0, 3, 10, acc);
      check("fl_filled", acc, 3);
      flush = 1'b1;
      apply(tbl[5]);
      in_valid = 1'b1;
      @(negedge clk);
      check("fl_in_ready", in_ready, 0);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      check("fl_out_valid", out_valid, 0);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("fl_no_accept", out_valid, 0);
      send(tbl[12]);
      wait_drain("drain_after_flush");
      repeat (3) @(posedge clk);

      // asynchronous reset in the middle of a stalled stream
      out_ready = 1'b0;
      stream(0, 2, 10, acc);
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_out_f", out_f, 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      check("arst_stays_idle", out_valid, 0);
      out_ready = 1'b1;

`ifdef ARITH_PIPE_CNT_EN
      check("cnt_reset", out_cnt, 0);
      stream(7, 5, 20, acc);
      wait_drain("drain_cnt");
      check("cnt_five", out_cnt, 5);
      out_ready = 1'b0;
      send(tbl[0]);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      check("cnt_after_flush", out_cnt, 5);
      out_ready = 1'b1;
      rst = 1'b1;
      #1;
      check("cnt_rst", out_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
`endif

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
